cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
Pipelined N-bit adder built from the existing 4-bit carry-lookahead slice, CLA_4. It adds one nibble per pipeline stage and registers the carry between stages, so it closes timing at wide widths. It accepts one operand pair per cycle under a valid/ready handshake and sits downstream of operand sourcing logic. It feeds the datapath result bus.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8. STAGES = WIDTH/4 is derived, not settable.

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair a/b/cin presented
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to nibble 0
out_valid  output  1  sum/cout/ovf valid
out_ready  input  1  consumer accepts result this cycle
sum  output  WIDTH  a+b+cin, modulo 2^WIDTH
cout  output  1  unsigned carry-out of the MSB
ovf  output  1  two's-complement signed overflow

Behaviour:
- Structure: STAGES pipeline stages. Stage k (0..STAGES-1) instantiates one CLA_4 on nibble k.
  - Its carry-in is cin for k=0, and the registered Co of stage k-1 otherwise.
  - Operand nibbles k+1..STAGES-1 are carried forward unchanged in skew registers.
  - Completed sum nibbles 0..k are carried forward in deskew registers.
  - Each stage has a valid bit v[k].
- The PG/GG outputs of CLA_4 are left unused.
- Transfer in: occurs when in_valid && in_ready. Stage 0 captures a, b, cin.
- Transfer out: occurs when out_valid && out_ready.
- Stall: global stall = out_valid && !out_ready.
  - On stall, every stage register, including the v[] bits, holds its value.
  - On no stall, all stages advance one position. v[0] <= in_valid.
- in_ready = !stall. This path is combinational from out_ready and intentionally has no skid buffer.
- Latency: accept at edge t gives out_valid high after edge t+STAGES-1 (4 cycles for WIDTH=16), assuming no stall. Throughput is 1 result per cycle.
- Outputs are driven from the final stage registers:
  - out_valid = v[STAGES-1]
  - sum = concatenation of the registered nibbles
  - cout = registered Co of the last slice
  - ovf = (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]), using the operand MSBs carried through the skew registers. ovf is registered with the result.
- Bubbles: when in_valid is low and there is no stall, an invalid entry (v=0) advances. Data registers may update with don't-care values. out_valid gates all result interpretation.
- Simultaneous events: a final-stage result can be taken in the same cycle a new pair is accepted. Pipeline occupancy is then unchanged.
- Stall with a bubble ahead: the pipeline does not compress. The whole pipe freezes while the output is stalled. This is the accepted cost of the simple design.
- Reset (async, active-high): all v[] bits clear immediately, giving out_valid=0. sum=0, cout=0 and ovf=0 (all data registers clear to 0). in_ready=1 while reset is deasserted and out_valid=0.
- Reset mid-operation: all in-flight results are discarded. No result is produced for pairs accepted before the reset.
- Arithmetic: sum and cout together equal the (WIDTH+1)-bit result of a+b+cin. Wrap-around is modulo 2^WIDTH. cout and ovf are independent flags.
- X-safety: with rst high, every output must be a known value regardless of the inputs.

Test Plan:
1. Basic latency, WIDTH=16, out_ready=1.
   - Stimulus: a=0x1234, b=0x4321, cin=0 accepted at cycle 0.
   - Required: out_valid first high after 4 edges, with sum=0x5555, cout=0, ovf=0. out_valid high for exactly one cycle.
2. Full carry chain across all stages.
   - Stimulus: a=0xFFFF, b=0x0001, cin=0.
   - Required: sum=0x0000, cout=1, ovf=0.
   - Stimulus: a=0xFFFF, b=0x0000, cin=1.
   - Required: sum=0x0000, cout=1.
3. Signed overflow.
   - Stimulus: 0x7FFF+0x0001.
   - Required: sum=0x8000, ovf=1, cout=0.
   - Stimulus: 0x8000+0x8000.
   - Required: sum=0x0000, ovf=1, cout=1.
4. Streaming.
   - Stimulus: 64 back-to-back random pairs with out_ready=1.
   - Required: results emerge in order on 64 consecutive cycles, each matching a reference model. in_ready is constantly 1.
5. Backpressure.
   - Stimulus: fill the pipe with 4 pairs, then hold out_ready=0 for 5 cycles.
   - Required: in_ready=0 and out_valid, sum, cout, ovf all stable throughout. After release, all 4 results arrive in order with none lost or duplicated. in_valid held high during the stall must not be consumed.
6. Reset mid-operation.
   - Stimulus: assert rst asynchronously (between edges) with 3 entries in flight.
   - Required: out_valid, sum, cout, ovf drop to 0 immediately, with no results after release. A pair accepted after release completes with normal 4-cycle latency.

Source files
------------

// File: rtl/cla_pipe_adder_if.sv
// cla_pipe_adder_if: operand/result handshake bundle for cla_pipe_adder.
//   in_valid/in_ready : operand pair a, b, cin offered / accepted
//   out_valid/out_ready : result sum, cout, ovf offered / accepted
//   master : operand source and result consumer
//   slave  : the adder itself
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// CLA_4: 4-bit carry-lookahead slice.
//   A, B : nibble operands      Ci : carry in
//   S    : nibble sum           Co : carry out
//   PG   : group propagate      GG : group generate
module CLA_4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Ci,
    output logic [3:0] S,
    output logic       Co,
    output logic       PG,
    output logic       GG
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        p    = A ^ B;
        g    = A & B;
        c[0] = Ci;
        c[1] = g[0] | (p[0] & Ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & Ci);
        S    = p ^ c[3:0];
        Co   = c[4];
        PG   = &p;
        GG   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end
endmodule

// cla_pipe_adder: pipelined WIDTH-bit adder, one CLA_4 nibble per stage,
// carry registered between stages, valid/ready handshake with global stall.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of cla_pipe_adder_if (a, b, cin in; sum, cout, ovf out)
// WIDTH must be a multiple of 4 and at least 8.
module cla_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_pipe_adder_if.slave      bus
);
    localparam int STAGES = WIDTH / 4;

    // Stage k (k < STAGES-1) registers: operands for the remaining nibbles
    // (skew), completed sum nibbles 0..k (deskew) and the carry out of nibble k.
    // The last stage lands directly in the output registers.
    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  a_q    [STAGES-1];
    logic [WIDTH-1:0]  b_q    [STAGES-1];
    logic [WIDTH-1:0]  s_q    [STAGES-1];
    logic [WIDTH-1:0]  s_next [STAGES-1];
    logic              c_q    [STAGES-1];
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;

    logic [3:0]        nib_s  [STAGES];
    logic              nib_co [STAGES];
    logic [STAGES-1:0] unused_pg;
    logic [STAGES-1:0] unused_gg;

    logic              stall;

    assign stall        = v[STAGES-1] && !bus.out_ready;
    assign bus.in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [3:0] an;
        logic [3:0] bn;
        logic       ci;

        if (k == 0) begin : g_first
            assign an = bus.a[3:0];
            assign bn = bus.b[3:0];
            assign ci = bus.cin;
        end else begin : g_rest
            assign an = a_q[k-1][4*k +: 4];
            assign bn = b_q[k-1][4*k +: 4];
            assign ci = c_q[k-1];
        end

        CLA_4 u_cla (
            .A  (an),
            .B  (bn),
            .Ci (ci),
            .S  (nib_s[k]),
            .Co (nib_co[k]),
            .PG (unused_pg[k]),
            .GG (unused_gg[k])
        );
    end

    // Deskew: each stage inherits the finished low nibbles and inserts its own.
    always_comb begin
        for (int unsigned i = 0; i < STAGES - 1; i++) begin
            s_next[i] = '0;
        end
        s_next[0][3:0] = nib_s[0];
        for (int unsigned i = 1; i < STAGES - 1; i++) begin
            s_next[i]            = s_q[i-1];
            s_next[i][4*i +: 4]  = nib_s[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v      <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            for (int unsigned i = 0; i < STAGES - 1; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
                c_q[i] <= 1'b0;
            end
        end else if (!stall) begin
            v      <= {v[STAGES-2:0], bus.in_valid};
            a_q[0] <= bus.a;
            b_q[0] <= bus.b;
            for (int unsigned i = 1; i < STAGES - 1; i++) begin
                a_q[i] <= a_q[i-1];
                b_q[i] <= b_q[i-1];
            end
            for (int unsigned i = 0; i < STAGES - 1; i++) begin
                s_q[i] <= s_next[i];
                c_q[i] <= nib_co[i];
            end
            sum_q  <= {nib_s[STAGES-1], s_q[STAGES-2][WIDTH-5:0]};
            cout_q <= nib_co[STAGES-1];
            // Signed overflow from the operand MSBs carried in the skew registers.
            ovf_q  <= (a_q[STAGES-2][WIDTH-1] == b_q[STAGES-2][WIDTH-1]) &&
                      (nib_s[STAGES-1][3] != a_q[STAGES-2][WIDTH-1]);
        end
    end

    assign bus.out_valid = v[STAGES-1];
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   n_out = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(16)) ifc ();

    cla_pipe_adder #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Result packed as {cout, ovf, sum}, from plain integer arithmetic.
    function automatic logic [17:0] model(logic [15:0] x, logic [15:0] y, logic c);
        int unsigned u;
        int sx;
        int sy;
        int s;
        logic co;
        logic o;
        u  = 32'(x) + 32'(y) + 32'(c);
        sx = int'($signed(x));
        sy = int'($signed(y));
        s  = sx + sy + int'(c);
        co = (u > 32'hFFFF);
        o  = (s > 32767) || (s < -32768);
        return {co, o, u[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [17:0] outs();
        return {ifc.cout, ifc.ovf, ifc.sum};
    endfunction

    // Inputs are set by the caller at the falling edge; sample, score, then clock.
    task automatic step();
        logic [17:0] r;
        #1;
        if (ifc.out_valid && ifc.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(outs()), 32'h3FFFF);
            end else begin
                r = exp_q.pop_front();
                chk("model_result", 32'(outs()), 32'(r));
            end
        end
        if (ifc.in_valid && ifc.in_ready) exp_q.push_back(model(ifc.a, ifc.b, ifc.cin));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic c, input logic [17:0] expv);
        bit seen;
        seen = 1'b0;
        ifc.in_valid = 1'b1; ifc.a = x; ifc.b = y; ifc.cin = c;
        step();
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            #1;
            if (ifc.out_valid) begin
                chk(tag, 32'(outs()), 32'(expv));
                seen = 1'b1;
            end
            step();
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic [17:0] snap;
        int base;

        ifc.in_valid  = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.cin       = 1'b0;
        ifc.out_ready = 1'b1;

        // Reset state with rst held high
        #12;
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_outputs",   32'(outs()),        32'd0);
        chk("rst_in_ready",  32'(ifc.in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1. Basic latency
        ifc.in_valid = 1'b1; ifc.a = 16'h1234; ifc.b = 16'h4321; ifc.cin = 1'b0;
        step();
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("lat_early", 32'(ifc.out_valid), 32'd0);
            step();
        end
        #1;
        chk("lat_valid",  32'(ifc.out_valid), 32'd1);
        chk("lat_result", 32'(outs()),        32'(18'h05555));
        step();
        #1 chk("lat_one_cycle", 32'(ifc.out_valid), 32'd0);
        step();

        // 2/3. Carry chain and signed overflow, checked against fixed values
        directed("carry_ffff_1",  16'hFFFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h0000});
        directed("carry_ffff_ci", 16'hFFFF, 16'h0000, 1'b1, {1'b1, 1'b0, 16'h0000});
        directed("ovf_7fff_1",    16'h7FFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h8000});
        directed("ovf_8000_8000", 16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, 16'h0000});

        // 4. Streaming 64 random pairs
        base = n_out;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ifc.in_valid = 1'b1;
            ifc.a = 16'($urandom); ifc.b = 16'($urandom); ifc.cin = 1'($urandom);
            #1 chk("stream_in_ready", 32'(ifc.in_ready), 32'd1);
            if (i == 4) chk("stream_out_valid", 32'(ifc.out_valid), 32'd1);
            step();
        end
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("stream_count", 32'(n_out - base), 32'd64);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // 5. Backpressure
        base = n_out;
        for (int i = 0; i < 4; i++) begin
            ifc.in_valid = 1'b1;
            ifc.a = 16'($urandom); ifc.b = 16'($urandom); ifc.cin = 1'($urandom);
            step();
        end
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.a = 16'hDEAD; ifc.b = 16'hBEEF; ifc.cin = 1'b1;
        #1 snap = outs();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready",  32'(ifc.in_ready),  32'd0);
            chk("bp_out_valid", 32'(ifc.out_valid), 32'd1);
            chk("bp_hold",      32'(outs()),        32'(snap));
            step();
        end
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("bp_count", 32'(n_out - base), 32'd4);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // 6. Reset mid-operation with 3 entries in flight
        for (int i = 0; i < 3; i++) begin
            ifc.in_valid = 1'b1;
            ifc.a = 16'($urandom); ifc.b = 16'($urandom); ifc.cin = 1'($urandom);
            step();
        end
        ifc.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid",   32'(ifc.out_valid), 32'd0);
        chk("rst_mid_outputs", 32'(outs()),        32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 chk("post_rst_quiet", 32'(ifc.out_valid), 32'd0);
            step();
        end
        ifc.in_valid = 1'b1; ifc.a = 16'h0F0F; ifc.b = 16'h00F1; ifc.cin = 1'b1;
        step();
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("post_rst_early", 32'(ifc.out_valid), 32'd0);
            step();
        end
        #1;
        chk("post_rst_valid",  32'(ifc.out_valid), 32'd1);
        chk("post_rst_result", 32'(outs()),        32'(18'h01001));
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
